// File: rtl/icache_line_filler_pkg.sv
// Shared types and constants for the instruction-cache line refill engine.
// The line is fixed at 16 bytes, so the byte offset is always 4 bits.
package icache_line_filler_pkg;

   localparam int LINE_BYTES = 16;
   localparam int ADDR_W     = 32;
   localparam int OFF_RG_HI  = 3;
   localparam int OFF_RG_LO  = 0;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef logic [ADDR_W-1:0]           ADDR_TP;
   typedef logic [7:0]                  WORD_TP;
   typedef logic [127:0]                LINE_TP;
   typedef logic [OFF_RG_HI:OFF_RG_LO]  OFF_TP;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/icache_line_filler_if.sv
// Bundles the icache miss/line signals and the byte-wide RAM port.
// master = the filler; slave = the surrounding icache, arbiter and RAM.
interface icache_line_filler_if;
   import icache_line_filler_pkg::*;

   logic   flush;
   logic   req_ena;
   ADDR_TP req_addr;
   logic   done;
   LINE_TP line;
   logic   ram_req;
   logic   ram_gnt;
   ADDR_TP ram_a;
   WORD_TP ram_din;

   // ram_gnt is only meaningful while ram_req=1: a cycle with both high
   // transfers ram_a, and ram_din carries that byte in the following cycle.
   modport master (
      input  flush, req_ena, req_addr, ram_gnt, ram_din,
      output done, line, ram_req, ram_a
   );

   modport slave (
      output flush, req_ena, req_addr, ram_gnt, ram_din,
      input  done, line, ram_req, ram_a
   );

endinterface

// File: rtl/icache_line_filler.sv
// Refills one 16-byte icache line over a granted byte-wide RAM port and
// presents it with a single-cycle done pulse.
module icache_line_filler
   import icache_line_filler_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   icache_line_filler_if.master fill_if,
   output state_e               state_o
);

   state_e        state_q, state_d;
   logic          done_q, done_d;
   LINE_TP        line_q, line_d;
   logic [4:0]    issue_cnt_q, issue_cnt_d;
   logic          pend_v_q, pend_v_d;
   OFF_TP         pend_idx_q, pend_idx_d;
   logic [27:0]   base_q, base_d;
   logic          issue_open;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^fill_if.req_addr[OFF_RG_HI:OFF_RG_LO];
   assign issue_open       = (issue_cnt_q < 5'(LINE_BYTES));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         done_q      <= FALSE;
         line_q      <= '0;
         issue_cnt_q <= '0;
         pend_v_q    <= FALSE;
         pend_idx_q  <= '0;
         base_q      <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         line_q      <= line_d;
         issue_cnt_q <= issue_cnt_d;
         pend_v_q    <= pend_v_d;
         pend_idx_q  <= pend_idx_d;
         base_q      <= base_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      done_d          = done_q;
      line_d          = line_q;
      issue_cnt_d     = issue_cnt_q;
      pend_v_d        = pend_v_q;
      pend_idx_d      = pend_idx_q;
      base_d          = base_q;
      fill_if.ram_req = FALSE;
      fill_if.ram_a   = '0;

      case (state_q)
         IDLE: begin
            if (fill_if.req_ena) begin
               base_d      = fill_if.req_addr[ADDR_W-1:4];
               issue_cnt_d = '0;
               pend_v_d    = FALSE;
               state_d     = READ;
            end
         end
         READ: begin
            fill_if.ram_req = issue_open;
            // Offset is concatenated, not added, so it can never carry into the tag.
            fill_if.ram_a   = {base_q, issue_cnt_q[3:0]};
            pend_v_d        = issue_open && fill_if.ram_gnt;
            if (pend_v_d) begin
               pend_idx_d  = issue_cnt_q[3:0];
               issue_cnt_d = issue_cnt_q + 5'd1;
            end
            if (pend_v_q) begin
               line_d[{pend_idx_q, 3'b000} +: 8] = fill_if.ram_din;
               if (pend_idx_q == OFF_TP'(LINE_BYTES - 1)) begin
                  state_d = DONE;
                  done_d  = TRUE;
               end
            end
         end
         DONE: begin
            // The icache still holds its miss here; it must not retrigger a refill.
            done_d  = FALSE;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (fill_if.flush) begin
         state_d  = IDLE;
         pend_v_d = FALSE;
         done_d   = FALSE;
         line_d   = line_q;
      end
   end

   assign fill_if.done = done_q;
   assign fill_if.line = line_q;
   assign state_o      = state_q;

endmodule
